// File: rtl/tdm_demux_8.sv
// tdm_demux_8: receive end of an 8:1 TDM link.
// Aligns to the Frame marker and steers slot k of each frame into shadow lane k.
// When a frame completes, the whole frame is copied to Out at once and Frame_done
// pulses for one cycle.
// Optional feature: define TDM_DEMUX_PARITY_EN to add one XOR parity beat after
// slot LANES-1. Without it, Parity_err is tied low.

// One shadow lane: holds a slot word until the frame completes.
module tdm_demux_lane #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Capture the slot word when this lane is addressed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     q <= '0;
      else if (we) q <= d;
   end

endmodule

module tdm_demux_8 #(
   parameter int LANES = 8,
   parameter int SEL_W = 3,
   parameter int WIDTH = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       D_in,
   input  logic                   Valid_in,
   input  logic                   Frame,
   output logic [LANES*WIDTH-1:0] Out,
   output logic                   Frame_done,
   output logic [SEL_W-1:0]       Sel_out,
   output logic                   Locked,
   output logic                   Sync_err,
   output logic                   Parity_err
);

   localparam logic [SEL_W-1:0] LAST = SEL_W'(LANES - 1);
   localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   state_t                        state, state_nxt;
   logic [SEL_W-1:0]              slot, slot_nxt;
   logic [LANES-1:0]              we;
   logic [LANES-1:0][WIDTH-1:0]   shadow;
   logic [LANES-1:0][WIDTH-1:0]   out_nxt;
   logic                          out_ld;
   logic                          serr_nxt;
   logic                          midframe;
   logic [1:0]                    rst_pipe;
   logic                          rst_i;

`ifdef TDM_DEMUX_PARITY_EN
   logic                          par_ph, par_nxt;
   logic                          perr_nxt;
   logic [WIDTH-1:0]              par_calc;
`endif

   // Reset synchronizer: asserts with rst immediately, releases on a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rst_pipe <= 2'b11;
      else     rst_pipe <= {rst_pipe[0], 1'b0};
   end

   assign rst_i = rst_pipe[1];

   // Shadow lanes; each one captures only its own slot.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      tdm_demux_lane #(.WIDTH(WIDTH)) u_lane (
         .clk (clk),
         .rst (rst_i),
         .we  (we[k]),
         .d   (D_in),
         .q   (shadow[k])
      );
   end

`ifdef TDM_DEMUX_PARITY_EN
   // The parity beat counts as mid-frame, so a marker on it forces a resync.
   assign midframe = (slot != '0) || par_ph;

   // Running XOR of the captured slot words, compared with the parity beat.
   always_comb begin
      par_calc = '0;
      for (int k = 0; k < LANES; k++) par_calc ^= shadow[k];
   end
`else
   assign midframe = (slot != '0);
`endif

   // State, slot counter and parity-phase registers.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state  <= HUNT;
         slot   <= '0;
`ifdef TDM_DEMUX_PARITY_EN
         par_ph <= 1'b0;
`endif
      end else begin
         state  <= state_nxt;
         slot   <= slot_nxt;
`ifdef TDM_DEMUX_PARITY_EN
         par_ph <= par_nxt;
`endif
      end
   end

   // Next state, lane write enables and frame-completion decision.
   always_comb begin
      state_nxt = state;
      slot_nxt  = slot;
      we        = '0;
      out_ld    = 1'b0;
      serr_nxt  = 1'b0;
      out_nxt   = shadow;
`ifdef TDM_DEMUX_PARITY_EN
      par_nxt   = par_ph;
      perr_nxt  = 1'b0;
`else
      // The final beat is merged in directly, so Out updates one clock after it.
      out_nxt[LANES-1] = D_in;
`endif
      if (Valid_in) begin
         unique case (state)
            HUNT: begin
               if (Frame) begin
                  we[0]     = 1'b1;
                  slot_nxt  = ONE;
                  state_nxt = LOCKED;
`ifdef TDM_DEMUX_PARITY_EN
                  par_nxt   = 1'b0;
`endif
               end
            end
            LOCKED: begin
               if (Frame && midframe) begin
                  // Marker mid-frame: drop the partial frame and restart at slot 0.
                  serr_nxt = 1'b1;
                  we[0]    = 1'b1;
                  slot_nxt = ONE;
`ifdef TDM_DEMUX_PARITY_EN
                  par_nxt  = 1'b0;
`endif
               end
`ifdef TDM_DEMUX_PARITY_EN
               else if (par_ph) begin
                  par_nxt  = 1'b0;
                  slot_nxt = '0;
                  if (D_in == par_calc) begin
                     out_ld = 1'b1;
                  end else begin
                     perr_nxt  = 1'b1;
                     state_nxt = HUNT;
                  end
               end
`endif
               else begin
                  we[slot] = 1'b1;
                  slot_nxt = slot + ONE;
                  if (slot == LAST) begin
`ifdef TDM_DEMUX_PARITY_EN
                     par_nxt = 1'b1;
`else
                     out_ld  = 1'b1;
`endif
                  end
               end
            end
         endcase
      end
   end

   // Output frame register and one-cycle status strobes.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         Out        <= '0;
         Frame_done <= 1'b0;
         Sync_err   <= 1'b0;
      end else begin
         if (out_ld) Out <= out_nxt;
         Frame_done <= out_ld;
         Sync_err   <= serr_nxt;
      end
   end

`ifdef TDM_DEMUX_PARITY_EN
   // Parity mismatch strobe.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) Parity_err <= 1'b0;
      else       Parity_err <= perr_nxt;
   end
`else
   assign Parity_err = 1'b0;
`endif

   assign Sel_out = slot;
   assign Locked  = (state == LOCKED);

endmodule
